// File: rtl/index_seek_ctrl.sv
// Seek controller for the run-length-compressed capture buffer.
// Walks the stream from address 0 and stops at the word covering a target index.
module index_seek_ctrl #(
  parameter int width = 48,
  parameter int addr_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seek_req,
  input  logic [width-1:0]      seek_target,
  input  logic [addr_width-1:0] stream_len,
  output logic                  busy,
  output logic                  seek_done,
  output logic                  seek_hit,
  output logic [addr_width-1:0] seek_addr,
  output logic [15:0]           seek_value,
  output logic [width-1:0]      seek_base,
  output logic                  mem_rd,
  output logic [addr_width-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_rvalid
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    LIT0,
    LIT1,
    CNT
  } dec_t;

  state_t state, state_n;
  dec_t   dec, dec_n;

  logic [width-1:0]      target, target_n;
  logic [width-1:0]      acc, acc_n;
  logic [addr_width-1:0] len, len_n;
  logic [15:0]           last, last_n;

  logic                  busy_n;
  logic                  done_n;
  logic                  hit_n;
  logic [addr_width-1:0] seek_addr_n;
  logic [15:0]           value_n;
  logic [width-1:0]      base_n;
  logic                  mem_rd_n;
  logic [addr_width-1:0] mem_addr_n;

  logic [width-1:0]      w_ext;
  logic [width:0]        span_end;
  logic                  covered;
  logic [15:0]           cov_value;
  logic [width-1:0]      acc_upd;
  dec_t                  dec_upd;
  logic [addr_width-1:0] next_addr;
  logic                  at_end;

  assign next_addr = mem_addr + 1'b1;
  assign at_end    = (next_addr == len);

  // Run-length decode of the word in mem_rdata against the current accumulator.
  // The span end is one bit wider so a count near the top never wraps the test.
  always_comb begin
    w_ext     = width'(mem_rdata);
    span_end  = {1'b0, acc} + {1'b0, w_ext};
    covered   = 1'b0;
    cov_value = mem_rdata;
    acc_upd   = acc + width'(1);
    dec_upd   = LIT1;
    unique case (dec)
      LIT0: begin
        covered = (target == acc);
      end
      LIT1: begin
        covered = (target == acc);
        if (mem_rdata == last) begin
          dec_upd = CNT;
        end
      end
      CNT: begin
        covered   = (target >= acc) && ({1'b0, target} < span_end);
        cov_value = last;
        acc_upd   = acc + w_ext;
        dec_upd   = (mem_rdata == 16'hffff) ? CNT : LIT0;
      end
      default: begin
        covered = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_n     = state;
    dec_n       = dec;
    target_n    = target;
    len_n       = len;
    acc_n       = acc;
    last_n      = last;
    busy_n      = busy;
    done_n      = 1'b0;
    mem_rd_n    = 1'b0;
    mem_addr_n  = mem_addr;
    hit_n       = seek_hit;
    seek_addr_n = seek_addr;
    value_n     = seek_value;
    base_n      = seek_base;
    unique case (state)
      IDLE: begin
        if (seek_req) begin
          target_n = seek_target;
          len_n    = stream_len;
          acc_n    = '0;
          last_n   = '0;
          dec_n    = LIT0;
          if (stream_len == '0) begin
            state_n     = DONE;
            done_n      = 1'b1;
            hit_n       = 1'b0;
            seek_addr_n = '0;
            value_n     = '0;
            base_n      = '0;
          end else begin
            state_n    = WAIT;
            busy_n     = 1'b1;
            mem_rd_n   = 1'b1;
            mem_addr_n = '0;
          end
        end
      end
      WAIT: begin
        // Data cannot legally return in the strobe cycle itself.
        if (mem_rvalid && !mem_rd) begin
          acc_n  = acc_upd;
          last_n = (dec == CNT) ? last : mem_rdata;
          dec_n  = dec_upd;
          if (covered) begin
            state_n     = DONE;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            hit_n       = 1'b1;
            seek_addr_n = mem_addr;
            value_n     = cov_value;
            base_n      = acc;
          end else if (at_end) begin
            state_n     = DONE;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            hit_n       = 1'b0;
            seek_addr_n = mem_addr;
            value_n     = '0;
            base_n      = acc_upd;
          end else begin
            mem_rd_n   = 1'b1;
            mem_addr_n = next_addr;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dec        <= LIT0;
      target     <= '0;
      len        <= '0;
      acc        <= '0;
      last       <= '0;
      busy       <= 1'b0;
      seek_done  <= 1'b0;
      seek_hit   <= 1'b0;
      seek_addr  <= '0;
      seek_value <= '0;
      seek_base  <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_n;
      dec        <= dec_n;
      target     <= target_n;
      len        <= len_n;
      acc        <= acc_n;
      last       <= last_n;
      busy       <= busy_n;
      seek_done  <= done_n;
      seek_hit   <= hit_n;
      seek_addr  <= seek_addr_n;
      seek_value <= value_n;
      seek_base  <= base_n;
      mem_rd     <= mem_rd_n;
      mem_addr   <= mem_addr_n;
    end
  end

endmodule
